// File: rtl/edge_grant_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : edge_grant_arbiter_if
// Purpose  : Request-side and grant-side signal bundle of edge_grant_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface edge_grant_arbiter_if #(
  parameter int MAX_DESC = 16
) ();
  localparam int IDX_W = (MAX_DESC > 1) ? $clog2(MAX_DESC) : 1;

  logic [MAX_DESC-1:0] din;
  logic                gnt_rdy;
  logic [MAX_DESC-1:0] ovf_clr;
  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;
  logic [MAX_DESC-1:0] req_out;
  logic [MAX_DESC-1:0] ovf_out;

  modport master (
    output din,
    output gnt_rdy,
    output ovf_clr,
    input  gnt_vld,
    input  gnt_idx,
    input  req_out,
    input  ovf_out
  );

  modport slave (
    input  din,
    input  gnt_rdy,
    input  ovf_clr,
    output gnt_vld,
    output gnt_idx,
    output req_out,
    output ovf_out
  );
endinterface
`default_nettype wire

// File: rtl/edge_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edge_grant_arbiter
// Purpose  : Per-channel edge detection into sticky requests, arbitrated into
//            a single registered grant with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module edge_grant_arbiter #(
  parameter int MAX_DESC = 16,
  parameter int EDGE_TYP = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  edge_grant_arbiter_if.slave    bus
);
  localparam int                  IDX_W    = (MAX_DESC > 1) ? $clog2(MAX_DESC) : 1;
  localparam logic [MAX_DESC-1:0] ONE_LSB  = MAX_DESC'(1);
  localparam logic [IDX_W-1:0]    LAST_RST = IDX_W'(MAX_DESC - 1);

  logic [MAX_DESC-1:0] din_ff;
  logic [MAX_DESC-1:0] req;
  logic [MAX_DESC-1:0] ovf;
  logic [MAX_DESC-1:0] edge_det;
  logic [MAX_DESC-1:0] clr_vec;
  logic [MAX_DESC-1:0] req_nxt;
  logic [MAX_DESC-1:0] ovf_nxt;
  logic                gnt_vld_q;
  logic [IDX_W-1:0]    gnt_idx_q;
  logic [IDX_W-1:0]    last_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic                found;
  logic                loadable;
  logic                do_load;

  generate
    if (EDGE_TYP == 0) begin : g_edge_neg
      assign edge_det = (bus.din ^ din_ff) & ~bus.din;
    end else if (EDGE_TYP == 1) begin : g_edge_pos
      assign edge_det = (bus.din ^ din_ff) & bus.din;
    end else begin : g_edge_both
      assign edge_det = bus.din ^ din_ff;
    end
  endgenerate

  // Scan starts at 0 for fixed priority, or just past the last winner for round-robin.
  always_comb begin
    int                  cand;
    logic [MAX_DESC-1:0] shifted;
    found   = 1'b0;
    sel_idx = '0;
    cand    = 0;
    shifted = '0;
    for (int k = 0; k < MAX_DESC; k++) begin
      cand = (ARB_MODE == 1) ? (int'(last_idx) + 1 + k) : k;
      if (cand >= MAX_DESC) cand = cand - MAX_DESC;
      shifted = req >> cand;
      if (!found && shifted[0]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(cand);
      end
    end
  end

  assign loadable = ~gnt_vld_q | bus.gnt_rdy;
  assign do_load  = loadable & found;
  assign clr_vec  = do_load ? (ONE_LSB << sel_idx) : '0;

  // A fresh edge always re-arms the request; it only overflows if the old one survives.
  assign req_nxt  = (req & ~clr_vec) | edge_det;
  assign ovf_nxt  = (ovf & ~bus.ovf_clr) | (edge_det & req & ~clr_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      din_ff    <= '0;
      req       <= '0;
      ovf       <= '0;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
      last_idx  <= LAST_RST;
    end else begin
      din_ff <= bus.din;
      req    <= req_nxt;
      ovf    <= ovf_nxt;
      if (loadable) begin
        gnt_vld_q <= found;
        if (found) begin
          gnt_idx_q <= sel_idx;
          last_idx  <= sel_idx;
        end
      end
    end
  end

  assign bus.gnt_vld = gnt_vld_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.req_out = req;
  assign bus.ovf_out = ovf;
endmodule
`default_nettype wire
